dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_ram.sv | 37 +++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state type and address-check helper for the
// dmem_responder slice.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is rejected when it is not word aligned or falls past the last word.
  function automatic logic isAccessError(input logic [WORD_W-1:0] addr,
                                         input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word storage with byte-lane writes and one synchronous read port.
// Contents are deliberately never reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // On an enabled edge, sample the addressed word and commit the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      if (i_we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (i_wstrb[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding valid/ready memory responder.
// Define DMEM_WAIT_STATES_EN to insert WAIT_CYCLES wait states per access;
// without it every access goes straight to RESP with a latency of one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  logic              r_started;
  logic              r_reqReady;
  logic              r_rspValid;
  logic              r_rspErr;
  logic              r_rspIsRead;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic              w_accept;
  logic              w_accWe;
  logic [WORD_W-1:0] w_accAddr;
  logic [WORD_W-1:0] w_accWdata;
  logic [STRB_W-1:0] w_accWstrb;
  logic              w_accErr;
  logic              w_enterResp;
  logic [WORD_W-1:0] w_ramRdata;

`ifdef DMEM_WAIT_STATES_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] r_count;
`else
  // WAIT_CYCLES has no effect when wait states are compiled out.
  if (WAIT_CYCLES < 0) begin : g_unusedWaitCycles
  end
`endif

  assign w_accept = req_valid && req_ready;

  // When the memory access coincides with acceptance the live request is used,
  // otherwise the copy captured at acceptance.
  assign w_accWe    = (r_state == IDLE) ? req_we    : r_we;
  assign w_accAddr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_accWdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_accWstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;
  assign w_accErr   = isAccessError(w_accAddr, DEPTH);

`ifdef DMEM_WAIT_STATES_EN
  assign w_enterResp = (w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == WAIT) && (r_count == '0));
`else
  assign w_enterResp = w_accept;
`endif

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_enterResp && areset),
    .i_we    (w_accWe && !w_accErr),
    .i_addr  (w_accAddr[AW+1:2]),
    .i_wdata (w_accWdata),
    .i_wstrb (w_accWstrb),
    .o_rdata (w_ramRdata)
  );

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state     <= IDLE;
      r_started   <= 1'b0;
      r_reqReady  <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspErr    <= 1'b0;
      r_rspIsRead <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
`ifdef DMEM_WAIT_STATES_EN
      r_count     <= '0;
`endif
    end else begin
      r_started <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_wstrb    <= req_wstrb;
            r_reqReady <= 1'b0;
`ifdef DMEM_WAIT_STATES_EN
            if (WAIT_CYCLES == 0) begin
              r_state     <= RESP;
              r_rspValid  <= 1'b1;
              r_rspErr    <= w_accErr;
              r_rspIsRead <= !w_accWe && !w_accErr;
            end else begin
              r_state <= WAIT;
              r_count <= CNT_W'(WAIT_CYCLES - 1);
            end
`else
            r_state     <= RESP;
            r_rspValid  <= 1'b1;
            r_rspErr    <= w_accErr;
            r_rspIsRead <= !w_accWe && !w_accErr;
`endif
          end else begin
            r_reqReady <= 1'b1;
          end
        end
`ifdef DMEM_WAIT_STATES_EN
        WAIT: begin
          if (r_count == '0) begin
            r_state     <= RESP;
            r_rspValid  <= 1'b1;
            r_rspErr    <= w_accErr;
            r_rspIsRead <= !w_accWe && !w_accErr;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_reqReady && r_started;
  assign rsp_valid = r_rspValid;
  assign rsp_err   = r_rspErr;
  assign rsp_rdata = r_rspIsRead ? w_ramRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. Accepted requests are
// queued; expected data comes from a bench-side word model when the response appears.
module tb_dmem_responder;

  localparam int DEPTH_TB = 256;
  localparam int WAIT_TB  = 2;
`ifdef DMEM_WAIT_STATES_EN
  localparam int LAT = WAIT_TB + 1;
`else
  localparam int LAT = 1;
`endif
  localparam int SPACING = LAT + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          acc;
  } req_t;

  logic        clk;
  logic        areset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int testCount = 0;
  int failCount = 0;
  int cycle     = 0;

  req_t        reqQ[$];
  req_t        monReq;
  logic [31:0] model [DEPTH_TB];
  logic [7:0]  monIdx;
  logic [31:0] expRdata;
  logic        expErr;
  bit          inRsp        = 0;
  bit          expKnown     = 0;
  bit          checkSpacing = 0;
  bit          haveLast     = 0;
  int          lastAcc      = 0;

  dmem_responder #(
    .DEPTH       (DEPTH_TB),
    .WAIT_CYCLES (WAIT_TB)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Free-running clock and a cycle counter used for latency and spacing.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request from just after a rising edge and returns just after
  // the edge that accepted it, with req_valid still asserted.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    int guard = 0;
    @(posedge clk);
    #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  // Waits until the responder is idle with nothing outstanding.
  task automatic waitIdle();
    int guard = 0;
    @(negedge clk);
    while ((rsp_valid || !req_ready || reqQ.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("idleTimeout", 32'd0, 32'd1);
  endtask

  // One complete access; request inputs are scrambled after acceptance.
  task automatic doAccess(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    applyStimulus(we, addr, wdata, strb);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    waitIdle();
  endtask

  // Monitor: queue accepted requests, score responses against the word model.
  always @(negedge clk) begin
    if (!areset) begin
      reqQ.delete();
      inRsp    = 0;
      haveLast = 0;
    end else begin
      if (req_valid && req_ready) begin
        reqQ.push_back('{req_we, req_addr, req_wdata, req_wstrb, cycle});
        if (checkSpacing && haveLast) checkOutput("spacing", 32'(cycle - lastAcc), 32'(SPACING));
        lastAcc  = cycle;
        haveLast = 1;
      end
      if (rsp_valid) begin
        if (!inRsp) begin
          inRsp = 1;
          if (reqQ.size() == 0) begin
            expKnown = 0;
            checkOutput("unexpectedRsp", 32'd1, 32'd0);
          end else begin
            expKnown = 1;
            monReq   = reqQ.pop_front();
            monIdx   = monReq.addr[9:2];
            checkOutput("latency", 32'(cycle - monReq.acc), 32'(LAT));
            if (monReq.addr[1:0] != 2'b00 || monReq.addr[31:2] >= 30'(DEPTH_TB)) begin
              expRdata = 32'h0;
              expErr   = 1'b1;
            end else if (monReq.we) begin
              for (int b = 0; b < 4; b++)
                if (monReq.strb[b]) model[monIdx][8*b +: 8] = monReq.wdata[8*b +: 8];
              expRdata = 32'h0;
              expErr   = 1'b0;
            end else begin
              expRdata = model[monIdx];
              expErr   = 1'b0;
            end
          end
        end
        if (expKnown) begin
          checkOutput("rspRdata", rsp_rdata, expRdata);
          checkOutput("rspErr", 32'(rsp_err), 32'(expErr));
        end
        if (rsp_ready) inRsp = 0;
      end
    end
  end

  // Directed sequence: reset, data path, byte lanes, errors, stall, reset abort, throughput.
  initial begin
    int guard;
    areset    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReqReady", 32'(req_ready), 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRspRdata", rsp_rdata, 32'd0);
    checkOutput("rstRspErr", 32'(rsp_err), 32'd0);
    areset = 1'b1;
    checkOutput("preFlagReqReady", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("postFlagReqReady", 32'(req_ready), 32'd1);

    doAccess(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    doAccess(1'b0, 32'h10, 32'h0, 4'h0);
    doAccess(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    doAccess(1'b0, 32'h10, 32'h0, 4'h0);
    doAccess(1'b1, 32'h10, 32'h12345678, 4'b0000);
    doAccess(1'b0, 32'h10, 32'h0, 4'h0);
    doAccess(1'b0, 32'h12, 32'h0, 4'h0);
    doAccess(1'b0, 32'h400, 32'h0, 4'h0);
    doAccess(1'b1, 32'h400, 32'h55555555, 4'hF);
    doAccess(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF);
    doAccess(1'b0, 32'h10, 32'h0, 4'h0);
    doAccess(1'b1, 32'h3FC, 32'h89ABCDEF, 4'hF);
    doAccess(1'b0, 32'h3FC, 32'h0, 4'h0);

    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) checkOutput("stallRspTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h0BADCAFE;
    req_wstrb = 4'hF;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stallValid", 32'(rsp_valid), 32'd1);
      checkOutput("stallRdata", rsp_rdata, 32'hDEADBEAA);
      checkOutput("stallReqReady", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 32'h30, 32'h0BADCAFE, 4'hF);
    req_valid = 1'b0;
    waitIdle();
    doAccess(1'b0, 32'h30, 32'h0, 4'h0);

    doAccess(1'b1, 32'h20, 32'h11223344, 4'hF);
`ifdef DMEM_WAIT_STATES_EN
    applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    req_valid = 1'b0;
    areset    = 1'b0;
`else
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #1;
    areset    = 1'b0;
    req_valid = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midRstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("midRstReqReady", 32'(req_ready), 32'd0);
    areset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("noRspAfterRst", 32'(rsp_valid), 32'd0);
    end
    waitIdle();
    doAccess(1'b0, 32'h20, 32'h0, 4'h0);

    haveLast     = 0;
    checkSpacing = 1;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'h10203040 + 32'(i) * 32'h01010101, 4'hF);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0);
    req_valid = 1'b0;
    waitIdle();
    checkSpacing = 0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Absolute bound on simulated time.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
